// File: rtl/spmv_row_mac.sv
// spmv_row_mac: one sparse row dot product per stream of LANES-wide beats, results queued in a small FIFO.
// Latency 3 cycles from the row_last handshake to out_val; in_rdy reserves FIFO room for in-flight rows, so nothing stalls.
// Define SPMV_ROW_MAC_SAT_EN for saturating accumulation with a sticky per-row out_sat; otherwise the sum wraps.
module spmv_row_mac #(
    parameter int VEC_W      = 32,
    parameter int LANES      = 16,
    parameter int ACC_W      = 2*VEC_W+8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [LANES*VEC_W-1:0] in_mat_val,
    input  logic [LANES*VEC_W-1:0] in_vec_val,
    input  logic [LANES-1:0]       in_lane_mask,
    input  logic                   in_row_last,
    input  logic [15:0]            in_row_idx,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [15:0]            out_row_idx,
    output logic [ACC_W-1:0]       out_sum,
    output logic                   out_sat,
    output logic                   busy
);

    localparam int PROD_W = 2*VEC_W;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH+1);

    logic in_hs;
    logic push;
    logic pop;

    // ---------------- stage 1: per-lane products ----------------
    logic signed [PROD_W-1:0] prod_d [LANES];
    logic signed [PROD_W-1:0] prod_q [LANES];
    logic                     s1_vld_q;
    logic                     s1_last_q;
    logic [15:0]              s1_idx_q;

    for (genvar g = 0; g < LANES; g++) begin : g_mul
        logic signed [VEC_W-1:0]  mat_e;
        logic signed [VEC_W-1:0]  vec_e;
        logic signed [PROD_W-1:0] prod_full;
        assign mat_e     = in_mat_val[g*VEC_W +: VEC_W];
        assign vec_e     = in_vec_val[g*VEC_W +: VEC_W];
        assign prod_full = PROD_W'(mat_e) * PROD_W'(vec_e);
        assign prod_d[g] = in_lane_mask[g] ? prod_full : '0;
    end

    assign in_hs = in_val & in_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_idx_q  <= '0;
        end else begin
            s1_vld_q <= in_hs;
            if (in_hs) begin
                s1_last_q <= in_row_last;
                s1_idx_q  <= in_row_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_hs) begin
            prod_q <= prod_d;
        end
    end

    // ---------------- stage 2: sign-extended reduction ----------------
    logic signed [ACC_W-1:0] tree_sum;
    logic signed [ACC_W-1:0] s2_sum_q;
    logic                    s2_vld_q;
    logic                    s2_last_q;
    logic [15:0]             s2_idx_q;

    // Written as a chain; synthesis rebalances it into a tree.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + ACC_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_idx_q  <= '0;
            s2_sum_q  <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_last_q <= s1_last_q;
                s2_idx_q  <= s1_idx_q;
                s2_sum_q  <= tree_sum;
            end
        end
    end

    // ---------------- stage 3: row accumulator ----------------
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    row_open_q;
    logic                    row_open_d;

    assign push = s2_vld_q & s2_last_q;

    always_comb begin
        acc_d      = acc_q;
        row_open_d = row_open_q;
        if (s2_vld_q) begin
            if (s2_last_q) begin
                acc_d      = '0;
                row_open_d = 1'b0;
            end else begin
                acc_d      = acc_sum;
                row_open_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            row_open_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            row_open_q <= row_open_d;
        end
    end

    // ---------------- result FIFO ----------------
    logic [15:0]      fifo_idx_q [FIFO_DEPTH];
    logic [ACC_W-1:0] fifo_sum_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   rows_held;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop = out_val & out_rdy;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q] <= s2_idx_q;
            fifo_sum_q[wr_ptr_q] <= acc_sum;
        end
    end

    // Rows still in stages 1-2 already own a FIFO slot, so the push can never find it full.
    assign rows_held = (CNT_W+1)'(cnt_q)
                     + (CNT_W+1)'(s1_vld_q & s1_last_q)
                     + (CNT_W+1)'(s2_vld_q & s2_last_q);
    assign in_rdy    = rst_n & (rows_held < (CNT_W+1)'(FIFO_DEPTH));

    assign out_val     = (cnt_q != '0);
    assign out_row_idx = out_val ? fifo_idx_q[rd_ptr_q] : '0;
    assign out_sum     = out_val ? fifo_sum_q[rd_ptr_q] : '0;
    assign busy        = s1_vld_q | s2_vld_q | row_open_q;

`ifdef SPMV_ROW_MAC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] sum_wide;
    logic           ovf;
    logic           row_sat;
    logic           sat_q;
    logic           sat_d;
    logic           fifo_sat_q [FIFO_DEPTH];

    assign sum_wide = {acc_q[ACC_W-1], acc_q} + {s2_sum_q[ACC_W-1], s2_sum_q};
    assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    assign acc_sum  = !ovf ? sum_wide[ACC_W-1:0] : (sum_wide[ACC_W] ? ACC_MIN : ACC_MAX);
    assign row_sat  = sat_q | (s2_vld_q & ovf);

    always_comb begin
        sat_d = sat_q;
        if (s2_vld_q) begin
            sat_d = s2_last_q ? 1'b0 : row_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_sat_q[wr_ptr_q] <= row_sat;
        end
    end

    assign out_sat = out_val & fifo_sat_q[rd_ptr_q];
`else
    assign acc_sum = acc_q + s2_sum_q;
    assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_spmv_row_mac.sv
// Bench for spmv_row_mac: row-level reference model with per-cycle compare, plus directed literal cases.
module tb_spmv_row_mac;

    localparam int VEC_W = 32;
    localparam int LANES = 16;
    localparam int ACC_W = 2*VEC_W+8;
    localparam int DEPTH = 4;
    localparam int BW    = LANES*VEC_W;
    localparam logic signed [127:0] ACC_MAX = (128'sd1 <<< (ACC_W-1)) - 128'sd1;
    localparam logic signed [127:0] ACC_MIN = -(128'sd1 <<< (ACC_W-1));

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_val;
    logic             in_rdy;
    logic [BW-1:0]    in_mat_val;
    logic [BW-1:0]    in_vec_val;
    logic [LANES-1:0] in_lane_mask;
    logic             in_row_last;
    logic [15:0]      in_row_idx;
    logic             out_val;
    logic             out_rdy;
    logic [15:0]      out_row_idx;
    logic [ACC_W-1:0] out_sum;
    logic             out_sat;
    logic             busy;

    spmv_row_mac #(.VEC_W(VEC_W), .LANES(LANES), .ACC_W(ACC_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_val(in_val), .in_rdy(in_rdy),
        .in_mat_val(in_mat_val), .in_vec_val(in_vec_val),
        .in_lane_mask(in_lane_mask), .in_row_last(in_row_last), .in_row_idx(in_row_idx),
        .out_val(out_val), .out_rdy(out_rdy),
        .out_row_idx(out_row_idx), .out_sum(out_sum), .out_sat(out_sat),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_sum(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int               ready;
        logic             last;
        logic [15:0]      idx;
        logic [ACC_W-1:0] sum;
        logic             sat;
    } beat_t;

    typedef struct {
        logic [15:0]      idx;
        logic [ACC_W-1:0] sum;
        logic             sat;
    } res_t;

    beat_t              pend[$];
    res_t               mfifo[$];
    logic signed [127:0] m_acc = 0;
    logic               m_sat = 1'b0;
    logic               m_open = 1'b0;
    int                 cyc = 0;

    function automatic logic signed [127:0] beat_sum(input logic [BW-1:0] m, input logic [BW-1:0] v,
                                                     input logic [LANES-1:0] mk);
        logic signed [127:0] s;
        logic signed [VEC_W-1:0] a;
        logic signed [VEC_W-1:0] b;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            if (mk[i]) begin
                a = m[i*VEC_W +: VEC_W];
                b = v[i*VEC_W +: VEC_W];
                s = s + 128'(a) * 128'(b);
            end
        end
        return s;
    endfunction

    always @(negedge clk) begin
        logic signed [127:0] t;
        logic [ACC_W-1:0]    tr;
        beat_t               bt;
        res_t                rs;
        int                  lasts;
        cyc++;
        if (!rst_n) begin
            pend.delete();
            mfifo.delete();
            m_acc  = 0;
            m_sat  = 1'b0;
            m_open = 1'b0;
            check("rst_out_val", out_val, 0);
            check("rst_in_rdy", in_rdy, 0);
            check("rst_busy", busy, 0);
            check("rst_out_row_idx", out_row_idx, 0);
            check("rst_out_sat", out_sat, 0);
            check_sum("rst_out_sum", out_sum, '0);
        end else begin
            while (pend.size() > 0 && pend[0].ready <= cyc) begin
                bt = pend.pop_front();
                if (bt.last) begin
                    rs.idx = bt.idx; rs.sum = bt.sum; rs.sat = bt.sat;
                    mfifo.push_back(rs);
                    m_open = 1'b0;
                end else begin
                    m_open = 1'b1;
                end
            end
            check("model_out_val", out_val, (mfifo.size() > 0) ? 1 : 0);
            if (out_val && mfifo.size() > 0) begin
                check("model_out_row_idx", out_row_idx, mfifo[0].idx);
                check_sum("model_out_sum", out_sum, mfifo[0].sum);
                check("model_out_sat", out_sat, mfifo[0].sat);
            end
            lasts = 0;
            foreach (pend[i]) if (pend[i].last) lasts++;
            check("model_in_rdy", in_rdy, (mfifo.size() + lasts < DEPTH) ? 1 : 0);
            check("model_busy", busy, (pend.size() > 0 || m_open) ? 1 : 0);
            if (out_val && out_rdy && mfifo.size() > 0) void'(mfifo.pop_front());
            if (in_val && in_rdy) begin
                t = m_acc + beat_sum(in_mat_val, in_vec_val, in_lane_mask);
`ifdef SPMV_ROW_MAC_SAT_EN
                if (t > ACC_MAX) begin
                    t = ACC_MAX; m_sat = 1'b1;
                end else if (t < ACC_MIN) begin
                    t = ACC_MIN; m_sat = 1'b1;
                end
`else
                tr = t[ACC_W-1:0];
                t  = 128'(signed'(tr));
`endif
                m_acc    = t;
                bt.ready = cyc + 3;
                bt.last  = in_row_last;
                bt.idx   = in_row_idx;
                bt.sum   = m_acc[ACC_W-1:0];
                bt.sat   = m_sat;
                pend.push_back(bt);
                if (in_row_last) begin
                    m_acc = 0;
                    m_sat = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [BW-1:0] m, input logic [BW-1:0] v, input logic [LANES-1:0] mk,
                            input logic last, input logic [15:0] idx);
        in_val = 1'b1; in_mat_val = m; in_vec_val = v;
        in_lane_mask = mk; in_row_last = last; in_row_idx = idx;
    endtask

    task automatic idle();
        in_val = 1'b0; in_row_last = 1'b0;
    endtask

    task automatic send(input logic [BW-1:0] m, input logic [BW-1:0] v, input logic [LANES-1:0] mk,
                        input logic last, input logic [15:0] idx);
        logic ok;
        int   t;
        ok = 1'b0; t = 0;
        set_beat(m, v, mk, last, idx);
        while (!ok) begin
            @(negedge clk);
            ok = in_rdy;
            tick();
            t++;
            if (!ok && t > 50) begin
                n_tests++; n_fail++;
                $display("FAIL send_timeout: in_rdy low for %0d cycles, expected 1", t);
                ok = 1'b1;
            end
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_val && lat < 64);
        if (!out_val) begin
            n_tests++; n_fail++;
            $display("FAIL wait_out_timeout: out_val 0 after %0d cycles, expected 1", lat);
        end
    endtask

    function automatic logic [BW-1:0] fill(input logic [VEC_W-1:0] x);
        logic [BW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*VEC_W +: VEC_W] = x;
        return r;
    endfunction

    function automatic logic [BW-1:0] lane0(input logic [VEC_W-1:0] x);
        logic [BW-1:0] r;
        r = '0;
        r[VEC_W-1:0] = x;
        return r;
    endfunction

    function automatic logic [VEC_W-1:0] rnd_elem();
        if ($urandom_range(0, 1) == 1) return VEC_W'($urandom_range(0, 40)) - VEC_W'(20);
        return $urandom;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        int            lat;
        int            acc_n;
        logic [15:0]   got[$];
        logic [BW-1:0] m;
        logic [BW-1:0] v;

        rst_n = 1'b0; out_rdy = 1'b1;
        in_val = 1'b0; in_mat_val = '0; in_vec_val = '0;
        in_lane_mask = '0; in_row_last = 1'b0; in_row_idx = '0;
        repeat (3) @(negedge clk);
        check("reset_in_rdy", in_rdy, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_reset", in_rdy, 1);
        tick();

        // empty row straight after reset
        send('0, '0, '0, 1'b1, 16'd9);
        idle();
        wait_out(lat);
        check("empty_row_latency", lat, 3);
        check("empty_row_idx", out_row_idx, 9);
        check_sum("empty_row_sum", out_sum, '0);
        tick();

        // two active lanes, a masked junk lane
        m = '0; v = '0;
        m[0 +: VEC_W] = 32'sd2;   v[0 +: VEC_W] = 32'sd3;
        m[VEC_W +: VEC_W] = -32'sd4; v[VEC_W +: VEC_W] = 32'sd5;
        m[2*VEC_W +: VEC_W] = 32'sd100; v[2*VEC_W +: VEC_W] = 32'sd100;
        send(m, v, 16'h0003, 1'b1, 16'd7);
        idle();
        wait_out(lat);
        check("single_beat_latency", lat, 3);
        check("single_beat_idx", out_row_idx, 7);
        check_sum("single_beat_sum", out_sum, ACC_W'(-14));
        check("single_beat_sat", out_sat, 0);
        tick();

        // three-beat row, then an immediate next row
        send(fill(32'd1), fill(32'd1), 16'hFFFF, 1'b0, 16'hDEAD);
        send(fill(32'd1), fill(32'd1), 16'hFFFF, 1'b0, 16'hBEEF);
        send(fill(32'd1), fill(32'd1), 16'hFFFF, 1'b1, 16'd2);
        send(lane0(32'd2), lane0(32'd3), 16'h0001, 1'b1, 16'd3);
        idle();
        wait_out(lat);
        check("multi_beat_idx", out_row_idx, 2);
        check_sum("multi_beat_sum", out_sum, ACC_W'(48));
        wait_out(lat);
        check("next_row_idx", out_row_idx, 3);
        check_sum("next_row_sum", out_sum, ACC_W'(6));
        tick();

        // backpressure: six rows against a stalled consumer
        out_rdy = 1'b0;
        acc_n = 0;
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            if (c == 12) out_rdy = 1'b1;
            if (acc_n < 6) set_beat(lane0(VEC_W'(acc_n + 1)), lane0(32'd1), 16'h0001, 1'b1, 16'(20 + acc_n));
            else idle();
            @(negedge clk);
            if (c == 11) begin
                check("full_in_rdy", in_rdy, 0);
                check("full_accepted", acc_n, 4);
                check("full_out_val", out_val, 1);
                check("full_head_idx", out_row_idx, 20);
            end
            if (in_val && in_rdy) acc_n++;
            if (out_val && out_rdy) begin
                check_sum("drain_sum", out_sum, ACC_W'(got.size() + 1));
                got.push_back(out_row_idx);
            end
            tick();
        end
        idle();
        check("drain_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) check("drain_order", got[i], 20 + i);

        // overflow boundary: 32 beats of 16 * 2^62 reach exactly 2^(ACC_W-1)
        for (int b = 0; b < 32; b++)
            send(fill(32'h8000_0000), fill(32'h8000_0000), 16'hFFFF, (b == 31), 16'd12);
        idle();
        wait_out(lat);
        check("ovf_idx", out_row_idx, 12);
`ifdef SPMV_ROW_MAC_SAT_EN
        check_sum("ovf_sum", out_sum, {1'b0, {(ACC_W-1){1'b1}}});
        check("ovf_sat", out_sat, 1);
`else
        check_sum("ovf_sum", out_sum, {1'b1, {(ACC_W-1){1'b0}}});
        check("ovf_sat", out_sat, 0);
`endif
        tick();
        send(lane0(32'd1), lane0(32'd1), 16'h0001, 1'b1, 16'd13);
        idle();
        wait_out(lat);
        check_sum("after_ovf_sum", out_sum, ACC_W'(1));
        check("after_ovf_sat", out_sat, 0);
        tick();

        // reset with two beats of an open row in flight
        send(fill(32'd1), fill(32'd1), 16'hFFFF, 1'b0, 16'd0);
        send(fill(32'd1), fill(32'd1), 16'hFFFF, 1'b0, 16'd0);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_val", out_val, 0);
        check("midrst_busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_busy", busy, 0);
        check("postrst_out_val", out_val, 0);
        check("postrst_in_rdy", in_rdy, 1);
        tick();
        send(lane0(32'd5), lane0(32'd1), 16'h0001, 1'b1, 16'd11);
        idle();
        wait_out(lat);
        check("postrst_latency", lat, 3);
        check("postrst_idx", out_row_idx, 11);
        check_sum("postrst_sum", out_sum, ACC_W'(5));
        tick();

        // random traffic against the model
        for (int c = 0; c < 800; c++) begin
            for (int l = 0; l < LANES; l++) begin
                m[l*VEC_W +: VEC_W] = rnd_elem();
                v[l*VEC_W +: VEC_W] = rnd_elem();
            end
            in_mat_val   = m;
            in_vec_val   = v;
            in_lane_mask = LANES'($urandom);
            in_row_last  = ($urandom_range(0, 3) == 0);
            in_row_idx   = 16'($urandom);
            in_val       = ($urandom_range(0, 9) < 7);
            out_rdy      = ($urandom_range(0, 9) < ((c < 400) ? 4 : 8));
            tick();
        end
        idle();
        out_rdy = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        check("final_drained", out_val, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spmv_row_mac.md
SPMV_ROW_MAC -- requirements
Module: spmv_row_mac

Interface
REQ-001 SHALL have parameter VEC_W, default 32: width of each signed matrix and vector element.
REQ-002 SHALL have parameter LANES, default 16: number of nonzero products presented per input beat.
REQ-003 SHALL have parameter ACC_W, default 2*VEC_W+8: accumulator and output sum width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: number of output result entries.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert and active-low.
REQ-007 SHALL have port in_val, input, 1 bit: input beat valid.
REQ-008 SHALL have port in_rdy, output, 1 bit: block accepts a beat this cycle.
REQ-009 SHALL have port in_mat_val, input, LANES*VEC_W bits: matrix nonzeros; lane i occupies bits [i*VEC_W +: VEC_W].
REQ-010 SHALL have port in_vec_val, input, LANES*VEC_W bits: gathered vector components (vec_file col_val_out), same lane packing.
REQ-011 SHALL have port in_lane_mask, input, LANES bits: lane i contributes only when bit i is 1.
REQ-012 SHALL have port in_row_last, input, 1 bit: beat closes the current row.
REQ-013 SHALL have port in_row_idx, input, 16 bits: row index, sampled only on a row_last beat.
REQ-014 SHALL have port out_val, output, 1 bit: FIFO head is valid.
REQ-015 SHALL have port out_rdy, input, 1 bit: consumer accepts the head.
REQ-016 SHALL have port out_row_idx, output, 16 bits: row index of the head entry.
REQ-017 SHALL have port out_sum, output, ACC_W bits: signed row dot product of the head entry.
REQ-018 SHALL have port out_sat, output, 1 bit: head entry saturated during accumulation.
REQ-019 SHALL have port busy, output, 1 bit: any pipeline stage valid, or partial row accumulated.

Function
REQ-020 SHALL complete an input handshake when in_val and in_rdy are both 1 on a rising edge; an output handshake when out_val and out_rdy are both 1.
REQ-021 SHALL register all LANES signed products, each 2*VEC_W bits and full precision, in stage 1; masked lanes SHALL produce 0.
REQ-022 SHALL reduce the products through a registered sign-extended adder tree to one ACC_W value in stage 2.
REQ-023 SHALL add the stage-2 sum to the row accumulator in stage 3; a row_last beat SHALL write {row_idx, acc+sum, sat} to the FIFO and clear the accumulator to 0 in the same cycle.
REQ-024 SHALL give a latency of 3 cycles from a row_last input handshake to out_val, when the FIFO is empty.
REQ-025 SHALL drive in_rdy = 1 only when FIFO occupancy plus the row_last beats held in stages 1-2 is less than FIFO_DEPTH; the FIFO therefore never overflows and the pipeline never stalls.
REQ-026 SHALL emit a result for a row_last beat with an all-zero mask, equal to the accumulated partial sum (0 for an empty row).
REQ-027 SHALL start the next row from 0 when a non-last beat follows a row_last beat in the next cycle; there SHALL be no bubble.
REQ-028 SHALL make a FIFO push and pop in the same cycle leave the occupancy unchanged; when full-with-pop, the push SHALL succeed.
REQ-029 SHALL wrap FIFO pointers modulo FIFO_DEPTH; out_* SHALL hold stable while out_val=1 and out_rdy=0.
REQ-030 SHALL accumulate modulo 2^ACC_W with out_sat=0 when the configuration feature is absent.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously clear stage valids, accumulator, sat flag, FIFO pointers and occupancy.
REQ-032 SHALL, during reset, drive out_val=0, in_rdy=0, busy=0, out_sum=0, out_row_idx=0 and out_sat=0.
REQ-033 SHALL drive in_rdy=1 in the first cycle after rst_n deasserts; reset mid-row SHALL discard the partial row and any in-flight beats.

Configuration
REQ-034 SHALL, when macro SPMV_ROW_MAC_SAT_EN is defined, clamp stage-3 accumulation to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set a sticky per-row sat flag, cleared at row_last.
REQ-035 SHALL, when SPMV_ROW_MAC_SAT_EN is undefined, behave per REQ-030 and tie out_sat to 0.

Verification
REQ-036 SHALL check: single beat, mask=0x0003, lanes {2*3, -4*5}, row_last, idx=7 -> out_val at +3 cycles with row 7, sum -14.
REQ-037 SHALL check: row spread over 3 beats, every lane 1*1, mask 0xFFFF, last on beat 3, idx=2 -> sum 48; the next row starts at 0.
REQ-038 SHALL check: out_rdy=0, 6 back-to-back single-beat rows -> in_rdy drops after 4 are committed, no loss; out_rdy=1 -> rows drain in order.
REQ-039 SHALL check: row_last with mask 0, idx=9, straight after reset -> sum 0, row 9.
REQ-040 SHALL check, with SPMV_ROW_MAC_SAT_EN: positive products exceeding 2^(ACC_W-1)-1 -> sum clamps to max and out_sat=1; without the macro, the sum wraps and out_sat=0.
REQ-041 SHALL check: rst_n pulsed mid-row with 2 beats in flight -> out_val stays 0, busy=0, and the next row's sum excludes the pre-reset beats.
